// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared defaults, status encoding and queue entry type for fetch.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    localparam int          FETCH_XLEN        = 32;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0001_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        RUN   = 2'd1,
        FULL  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_if
// Purpose  : Redirect, instruction-memory and IF/ID signals of the fetch stage.
// Revision : 1.0
// ============================================================================
interface fetch_prefetch_if #(
    parameter int XLEN = 32
);
    logic            redirect_early_valid;
    logic [XLEN-1:0] redirect_early_pc;
    logic            redirect_late_valid;
    logic [XLEN-1:0] redirect_late_pc;

    logic            ireq;
    logic [XLEN-1:0] iaddr;
    logic            iready_n;
    logic [XLEN-1:0] idata;

    logic            if_valid;
    logic            id_ready;
    logic [XLEN-1:0] inst_out;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pcp4_out;
    logic [4:0]      rs1_out;
    logic [4:0]      rs2_out;

    modport master (
        input  redirect_early_valid, redirect_early_pc,
        input  redirect_late_valid,  redirect_late_pc,
        output ireq, iaddr,
        input  iready_n, idata,
        output if_valid,
        input  id_ready,
        output inst_out, pc_out, pcp4_out, rs1_out, rs2_out
    );

    modport slave (
        output redirect_early_valid, redirect_early_pc,
        output redirect_late_valid,  redirect_late_pc,
        input  ireq, iaddr,
        output iready_n, idata,
        input  if_valid,
        output id_ready,
        input  inst_out, pc_out, pcp4_out, rs1_out, rs2_out
    );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Prefetch queue storage with wrap-around pointers and flush.
// Revision : 1.0
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     flush_i,
    input  wire logic                     push_i,
    input  wire logic                     pop_i,
    input  wire logic [WIDTH-1:0]         wdata_i,
    output logic      [WIDTH-1:0]         rdata_o,
    output logic      [$clog2(DEPTH):0]   count_o,
    output logic      [$clog2(DEPTH):0]   count_d_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push_i & (count_q != CW'(DEPTH));
    assign do_pop  = pop_i  & (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign rdata_o   = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign count_d_o = count_d;

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch
// Purpose  : Sequential fetch into a prefetch queue with early/late redirect.
// Revision : 1.0
// ============================================================================
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fetch_prefetch_if.master   bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 2 * XLEN;

    logic [XLEN-1:0] iaddr_q;
    logic [XLEN-1:0] iaddr_d;
    fetch_state_t    state_q;

    logic [CW-1:0]   count;
    logic [CW-1:0]   count_d;
    logic [EW-1:0]   head;
    logic            redirect;
    logic [XLEN-1:0] target;
    logic            full;
    logic            ireq;
    logic            push;
    logic            pop;
    logic            valid;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] inst;

    // Late redirect wins: it belongs to the older instruction in EX.
    assign redirect = bus.redirect_late_valid | bus.redirect_early_valid;
    assign target   = bus.redirect_late_valid ? bus.redirect_late_pc
                                              : bus.redirect_early_pc;

    assign full  = (count == CW'(DEPTH));
    assign ireq  = rst & ~full;
    assign push  = ireq & ~bus.iready_n & ~redirect;
    assign valid = (count != '0);
    assign pop   = valid & bus.id_ready;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (redirect),
        .push_i    (push),
        .pop_i     (pop),
        .wdata_i   ({iaddr_q, bus.idata}),
        .rdata_o   (head),
        .count_o   (count),
        .count_d_o (count_d)
    );

    always_comb begin
        iaddr_d = iaddr_q;
        if (redirect) begin
            iaddr_d = target;
        end else if (push) begin
            iaddr_d = iaddr_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iaddr_q <= RESET_PC;
        end else begin
            iaddr_q <= iaddr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else if (redirect) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (push) state_q <= RUN;
                RUN: begin
                    if (count_d == CW'(DEPTH)) begin
                        state_q <= FULL;
                    end else if (count_d == '0) begin
                        state_q <= EMPTY;
                    end
                end
                FULL:    if (pop) state_q <= RUN;
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign head_pc = head[EW-1 -: XLEN];
    assign inst    = valid ? head[XLEN-1:0] : NOP_INSTR;

    assign bus.ireq     = ireq;
    assign bus.iaddr    = iaddr_q;
    assign bus.if_valid = valid;
    assign bus.inst_out = inst;
    assign bus.pc_out   = head_pc;
    assign bus.pcp4_out = head_pc + XLEN'(4);
    assign bus.rs1_out  = inst[19:15];
    assign bus.rs2_out  = inst[24:20];

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_prefetch
// Purpose  : Randomised and directed checks of fetch_prefetch against a queue model.
// Revision : 1.0
// ============================================================================
module tb_fetch_prefetch;
    import fetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0001_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_entry_t m_q[$];
    logic [31:0]  m_iaddr;
    logic [31:0]  held;

    fetch_prefetch_if #(.XLEN(32)) bus();

    fetch_prefetch #(
        .XLEN      (32),
        .DEPTH     (DEPTH),
        .RESET_PC  (RPC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_iaddr = RPC;
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        if (!v) model_reset();
    endtask

    task automatic set_in(input bit ir_n, input bit idr, input bit ev, input logic [31:0] epc,
                          input bit lv, input logic [31:0] lpc);
        bus.iready_n             = ir_n;
        bus.id_ready             = idr;
        bus.redirect_early_valid = ev;
        bus.redirect_early_pc    = epc;
        bus.redirect_late_valid  = lv;
        bus.redirect_late_pc     = lpc;
        bus.idata                = $urandom;
    endtask

    // One clock edge of the reference behaviour, using the inputs held during the cycle.
    task automatic model_update();
        bit can_fetch;
        bit take;
        if (!rst) begin
            model_reset();
        end else begin
            can_fetch = (m_q.size() != DEPTH);
            take      = (m_q.size() != 0) && bus.id_ready;
            if (bus.redirect_late_valid) begin
                m_q.delete();
                m_iaddr = bus.redirect_late_pc;
            end else if (bus.redirect_early_valid) begin
                m_q.delete();
                m_iaddr = bus.redirect_early_pc;
            end else begin
                if (take) void'(m_q.pop_front());
                if (can_fetch && !bus.iready_n) begin
                    m_q.push_back('{pc: m_iaddr, inst: bus.idata});
                    m_iaddr = m_iaddr + 32'd4;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [31:0]  e_inst;
        fetch_state_t e_st;
        e_inst = (m_q.size() != 0) ? m_q[0].inst : NOP;
        e_st   = (m_q.size() == 0) ? EMPTY : (m_q.size() == DEPTH) ? FULL : RUN;
        chk("ireq",     32'(bus.ireq),     32'(rst && (m_q.size() != DEPTH)));
        chk("iaddr",    bus.iaddr,         m_iaddr);
        chk("if_valid", 32'(bus.if_valid), 32'(m_q.size() != 0));
        chk("inst_out", bus.inst_out,      e_inst);
        chk("rs1_out",  32'(bus.rs1_out),  32'(e_inst[19:15]));
        chk("rs2_out",  32'(bus.rs2_out),  32'(e_inst[24:20]));
        chk("state",    32'(dut.state_q),  32'(e_st));
        if (m_q.size() != 0) begin
            chk("pc_out",   bus.pc_out,   m_q[0].pc);
            chk("pcp4_out", bus.pcp4_out, m_q[0].pc + 32'd4);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic pulse_reset();
        set_rst(1'b0);
        #2;
        set_rst(1'b1);
    endtask

    initial begin
        rst = 1'b1;
        set_in(1, 0, 0, 0, 0, 0);
        #1 set_rst(1'b0);
        @(negedge clk);
        check_outputs();
        chk("rst_iaddr", bus.iaddr,         RPC);
        chk("rst_inst",  bus.inst_out,      NOP);
        chk("rst_valid", 32'(bus.if_valid), 32'd0);
        set_in(0, 1, 0, 0, 0, 0);
        cyc();

        // Streaming after release
        set_rst(1'b1);
        for (int i = 0; i < 8; i++) begin
            set_in(0, 1, 0, 0, 0, 0);
            cyc();
        end

        // Back-pressure fill, then drain in order
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 0, 0);
            cyc();
        end
        chk("fill_iaddr", bus.iaddr,        32'h0001_0010);
        chk("fill_ireq",  32'(bus.ireq),    32'd0);
        chk("fill_state", 32'(dut.state_q), 32'(FULL));
        chk("fill_head",  bus.pc_out,       32'h0001_0000);
        for (int i = 0; i < 6; i++) begin
            set_in(0, 1, 0, 0, 0, 0);
            cyc();
        end

        // Early redirect with three entries queued
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0);
            cyc();
        end
        set_in(0, 0, 1, 32'h2000, 0, 0);
        cyc();
        chk("erd_valid", 32'(bus.if_valid), 32'd0);
        chk("erd_inst",  bus.inst_out,      NOP);
        chk("erd_iaddr", bus.iaddr,         32'h2000);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 0, 0, 0, 0);
            cyc();
        end

        // Simultaneous early and late redirect
        set_in(0, 1, 1, 32'h3000, 1, 32'h4000);
        cyc();
        chk("both_iaddr", bus.iaddr, 32'h4000);
        set_in(0, 1, 0, 0, 0, 0);
        cyc();
        chk("both_head", bus.pc_out, 32'h4000);

        // Memory stall drains the queue while iaddr holds
        for (int i = 0; i < 5; i++) begin
            set_in(1, 1, 0, 0, 0, 0);
            cyc();
        end
        held = m_iaddr;
        chk("stall_valid", 32'(bus.if_valid), 32'd0);
        chk("stall_iaddr", bus.iaddr,         held);
        set_in(0, 1, 0, 0, 0, 0);
        cyc();
        chk("stall_head", bus.pc_out, held);

        // Asynchronous reset with two entries queued
        set_in(0, 0, 1, 32'h5000, 0, 0);
        cyc();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 0, 0, 0);
            cyc();
        end
        chk("pre_rst_valid", 32'(bus.if_valid), 32'd1);
        set_rst(1'b0);
        #1;
        chk("async_valid", 32'(bus.if_valid), 32'd0);
        chk("async_inst",  bus.inst_out,      NOP);
        set_in(0, 1, 0, 0, 0, 0);
        cyc();
        set_rst(1'b1);
        cyc();
        chk("post_rst_head", bus.pc_out, RPC);

        // Address wrap at the top of the space
        set_in(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        cyc();
        set_in(0, 0, 0, 0, 0, 0);
        cyc();
        chk("wrap_iaddr", bus.iaddr,  32'h0000_0000);
        chk("wrap_head",  bus.pc_out, 32'hFFFF_FFFC);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] epc;
            logic [31:0] lpc;
            epc = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            lpc = $urandom & 32'hFFFF_FFFC;
            set_in(($urandom_range(9) < 3), ($urandom_range(9) < 7),
                   ($urandom_range(19) == 0), epc, ($urandom_range(19) == 0), lpc);
            if ($urandom_range(199) == 0) begin
                set_rst(1'b0);
                #1;
                chk("rnd_async_valid", 32'(bus.if_valid), 32'd0);
            end else if (!rst) begin
                set_rst(1'b1);
            end
            cyc();
        end
        set_rst(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised successor to the single-entry fetch stage: it fetches sequentially from instruction memory into a DEPTH-entry prefetch queue and presents the oldest entry to IF/ID under a valid/ready handshake. Two redirect sources are supported: early branch from ID and late branch from EX. A redirect flushes the queue and restarts fetch at the target. The block sits between instruction memory and the IF/ID pipeline register.

## Interface
- XLEN, 32, address/instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0001_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, instruction presented when the queue is empty or squashed

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- redirect_early_valid  in  1  early (ID) branch taken
- redirect_early_pc  in  XLEN  early branch target
- redirect_late_valid  in  1  late (EX) branch taken
- redirect_late_pc  in  XLEN  late branch target
- ireq  out  1  fetch request this cycle
- iaddr  out  XLEN  fetch address, registered
- iready_n  in  1  low = idata valid for iaddr this cycle
- idata  in  XLEN  fetched instruction
- if_valid  out  1  head entry valid
- id_ready  in  1  IF/ID accepts the head this cycle
- inst_out  out  XLEN  head instruction, NOP_INSTR when !if_valid
- pc_out  out  XLEN  head PC
- pcp4_out  out  XLEN  head PC + 4
- rs1_out  out  5  inst_out[19:15]
- rs2_out  out  5  inst_out[24:20]

## Operation
- Queue holds {pc, inst} pairs. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- ireq = rst & (count != DEPTH). There is no combinational path from id_ready to ireq.
- Push occurs when ireq & !iready_n & no redirect:
  - write {iaddr, idata} at the write pointer;
  - iaddr <= iaddr + 4, modulo 2^XLEN; wrap at all-ones is silent.
- Pop occurs when if_valid & id_ready: advance the read pointer.
- Push and pop in the same cycle leave count unchanged. Full plus pop cannot coincide with a push, because ireq is low when the queue is full.
- iready_n high while ireq is asserted: hold iaddr, no push. This repeats indefinitely.
- Redirect priority: late over early. The late redirect belongs to the older instruction, which is a deliberate change from the earlier fetch stage.
- On any redirect:
  - count, rd_ptr and wr_ptr <= 0;
  - iaddr <= selected target;
  - the memory response of that cycle is discarded;
  - the pop of that cycle is still honoured by IF/ID, which applies its own squash.
- pcp4_out is pc_out + 4, computed combinationally from the head entry.
- Status FSM with states EMPTY, RUN and FULL, derived from count:
  - EMPTY to RUN on push;
  - RUN to FULL when count reaches DEPTH;
  - FULL to RUN on pop;
  - RUN to EMPTY when count reaches 0;
  - any state to EMPTY on redirect.

## Timing
- Reset values:
  - iaddr = RESET_PC, count = 0, pointers = 0, state = EMPTY;
  - if_valid = 0, inst_out = NOP_INSTR;
  - pc_out and pcp4_out are don't-care, but they are driven from entry 0, which resets to 0.
- Reset asserted mid-operation clears the queue immediately (asynchronous). Fetch restarts at RESET_PC on the first edge after release.
- Latency:
  - A response accepted at edge N is visible as the head after edge N when the queue was empty, so if_valid rises one cycle after the accept.
  - With a steady memory and id_ready held at 1, throughput is one instruction per cycle.
- Redirect latency:
  - iaddr equals the target one cycle after the redirect cycle;
  - the first post-redirect instruction reaches the head two cycles after the redirect.
- All outputs except ireq and the head-derived combinational fields are registers.

## Structure
- Shared package fetch_pkg holds:
  - RESET_PC_DEFAULT and NOP_INSTR_DEFAULT;
  - the fetch_state_t enum {EMPTY, RUN, FULL};
  - the fetch_entry_t struct {pc, inst}.
- Sub-module fetch_fifo(WIDTH, DEPTH) implements the storage, pointers, count and synchronous flush. fetch_prefetch holds iaddr, the redirect mux, the FSM and the output formatting.

## Test plan
- Reset release, memory always ready (iready_n = 0), id_ready = 1:
  - iaddr = 0x10000, 0x10004, 0x10008, … on consecutive cycles;
  - pc_out follows, one instruction per cycle;
  - pcp4_out = pc_out + 4.
- Back-pressure fill (id_ready = 0, DEPTH = 4): after 4 pushes, count = 4, state FULL, ireq = 0, iaddr = 0x10010. Then raise id_ready: heads appear in order at 0x10000..0x1000C.
- Early redirect to 0x2000 with 3 entries queued:
  - next cycle: count = 0, if_valid = 0, inst_out = NOP_INSTR, iaddr = 0x2000;
  - the response arriving in the redirect cycle is never popped.
- Simultaneous early (0x3000) and late (0x4000) redirects: iaddr = 0x4000 and the first head pc is 0x4000.
- iready_n held high for 5 cycles: iaddr stable, no push, queue drains to EMPTY. On release, the next head pc is the held iaddr.
- Asynchronous reset pulse mid-stream with count = 2: if_valid falls with no clock edge. After release, the first head pc is 0x10000.
- iaddr = 0xFFFF_FFFC: the next iaddr wraps to 0x0000_0000.
